// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one UART transmitter between NUM_REQ byte sources,
// granting round-robin at packet granularity with a mid-packet gap watchdog.
module uart_tx_sched #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned MAX_GAP = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    input  logic [NUM_REQ-1:0]         cfg_two_stop,
    input  logic [NUM_REQ-1:0]         cfg_odd_parity,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       tx_ready,
    input  logic                       tx_done,
    output logic [7:0]                 tx_data,
    output logic                       tx_start,
    output logic                       two_stop,
    output logic                       odd_parity,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       timeout,
    output logic [$clog2(NUM_REQ)-1:0] timeout_id
);

    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam int unsigned GW  = $clog2(MAX_GAP + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

    state_t           state, state_nxt;
    logic [IDW-1:0]   last_grant, last_grant_nxt;
    logic [IDW-1:0]   grant_idx, grant_idx_nxt;
    logic             last_r, last_nxt;
    logic [GW-1:0]    gap_cnt, gap_nxt;
    logic [NUM_REQ-1:0] grant_nxt;
    logic [7:0]       tx_data_nxt;
    logic             tx_start_nxt;
    logic             two_stop_nxt;
    logic             odd_parity_nxt;
    logic             timeout_nxt;
    logic [IDW-1:0]   timeout_id_nxt;

    logic             win_found;
    logic [IDW-1:0]   win_idx;
    logic [IDW-1:0]   scan_idx;

    logic             g_valid;
    logic             g_last;
    logic [7:0]       g_data;

    assign g_valid = req_valid[grant_idx];
    assign g_last  = req_last[grant_idx];
    assign g_data  = req_data[{grant_idx, 3'b000} +: 8];

    // Round-robin search: first valid requester after last_grant, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            scan_idx = IDW'((32'(last_grant) + k) % NUM_REQ);
            if (!win_found && req_valid[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        grant_idx_nxt  = grant_idx;
        last_nxt       = last_r;
        gap_nxt        = gap_cnt;
        grant_nxt      = grant;
        tx_data_nxt    = tx_data;
        tx_start_nxt   = 1'b0;
        two_stop_nxt   = two_stop;
        odd_parity_nxt = odd_parity;
        timeout_nxt    = 1'b0;
        timeout_id_nxt = timeout_id;
        req_ready      = '0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nxt            = LOAD;
                    grant_nxt            = '0;
                    grant_nxt[win_idx]   = 1'b1;
                    grant_idx_nxt        = win_idx;
                    last_grant_nxt       = win_idx;
                    two_stop_nxt         = cfg_two_stop[win_idx];
                    odd_parity_nxt       = cfg_odd_parity[win_idx];
                    gap_nxt              = '0;
                end
            end
            LOAD: begin
                if (gap_cnt == GW'(MAX_GAP - 1)) begin
                    // Gap budget exhausted: revoke (timeout already pulsed).
                    state_nxt = IDLE;
                    grant_nxt = '0;
                end else if (tx_ready && g_valid) begin
                    req_ready[grant_idx] = 1'b1;
                    tx_data_nxt          = g_data;
                    tx_start_nxt         = 1'b1;
                    last_nxt             = g_last;
                    gap_nxt              = '0;
                    state_nxt            = SEND;
                end else if (!g_valid) begin
                    gap_nxt = gap_cnt + GW'(1);
                    if (gap_cnt == GW'(MAX_GAP - 2)) begin
                        timeout_nxt    = 1'b1;
                        timeout_id_nxt = grant_idx;
                    end
                end
            end
            SEND: begin
                if (tx_done) begin
                    if (last_r) begin
                        state_nxt = IDLE;
                        grant_nxt = '0;
                    end else begin
                        state_nxt = LOAD;
                        gap_nxt   = '0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= IDW'(NUM_REQ - 1);
            grant_idx  <= '0;
            last_r     <= 1'b0;
            gap_cnt    <= '0;
            grant      <= '0;
            tx_data    <= 8'h00;
            tx_start   <= 1'b0;
            two_stop   <= 1'b0;
            odd_parity <= 1'b0;
            timeout    <= 1'b0;
            timeout_id <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            grant_idx  <= grant_idx_nxt;
            last_r     <= last_nxt;
            gap_cnt    <= gap_nxt;
            grant      <= grant_nxt;
            tx_data    <= tx_data_nxt;
            tx_start   <= tx_start_nxt;
            two_stop   <= two_stop_nxt;
            odd_parity <= odd_parity_nxt;
            timeout    <= timeout_nxt;
            timeout_id <= timeout_id_nxt;
        end
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit scheduler that shares one UART transmitter between `NUM_REQ` byte sources. It grants the transmitter round-robin, holds the grant for a whole packet (through `req_last`), and presents the winner's stop-bit and parity configuration for the packet's duration. It releases a stalled requester after `MAX_GAP` idle cycles. It sits between the byte producers and the UART transmitter's load/start interface.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `MAX_GAP`, 1024: cycles a granted requester may leave `req_valid` low mid-packet before its grant is revoked (≥2).
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in NUM_REQ: requester i has a byte on `req_data[8*i+:8]`.
- `req_data` in 8*NUM_REQ: byte per requester.
- `req_last` in NUM_REQ: the offered byte ends requester i's packet.
- `cfg_two_stop` in NUM_REQ: per-requester two-stop-bit setting.
- `cfg_odd_parity` in NUM_REQ: per-requester odd-parity setting.
- `req_ready` out NUM_REQ: combinational one-cycle accept strobe; a byte transfers when `req_valid[i] & req_ready[i]`.
- `tx_ready` in 1: the transmitter can accept a byte.
- `tx_done` in 1: one-cycle pulse when the transmitter finishes a frame.
- `tx_data` out 8: registered byte to the transmitter.
- `tx_start` out 1: registered one-cycle load/start pulse.
- `two_stop` out 1, `odd_parity` out 1: registered config for the granted requester.
- `grant` out NUM_REQ: registered one-hot grant, all zero when idle.
- `timeout` out 1: one-cycle pulse when a grant is revoked by the gap watchdog.
- `timeout_id` out clog2(NUM_REQ): index of the revoked requester, held until the next timeout.

## Operation
- Internal state: FSM {IDLE, LOAD, SEND}; `last_grant` pointer; `last_r` flag; `gap_cnt` of width clog2(MAX_GAP+1).
- Reset values:
  - All outputs are 0, including `tx_data` = 8'h00.
  - FSM is IDLE.
  - `last_grant` = NUM_REQ-1, so requester 0 has top priority first.
  - `gap_cnt` = 0.
- Reset is asynchronous. Asserting it mid-packet clears `tx_start` and `grant` immediately.
- IDLE:
  - If any `req_valid` is set, the winner is the first set bit searched from `last_grant`+1 upward, wrapping modulo NUM_REQ.
  - Next state is LOAD. `grant` is set to the winner.
  - `two_stop` and `odd_parity` latch the winner's cfg bits and stay constant until release.
  - `gap_cnt` is cleared.
  - `last_grant` is set to the winner.
- LOAD, with g the granted index:
  - If `tx_ready` and `req_valid[g]`:
    - `req_ready[g]` is 1 in this cycle.
    - `tx_data` <= `req_data[g]`, `tx_start` <= 1, `last_r` <= `req_last[g]`, `gap_cnt` <= 0.
    - Next state is SEND.
  - Else if `req_valid[g]` is 0, `gap_cnt` increments. When it reaches MAX_GAP-1 with `req_valid[g]` still 0:
    - `timeout` pulses and `timeout_id` = g.
    - `grant` clears. Next state is IDLE.
  - `tx_ready` low with `req_valid[g]` high does not advance `gap_cnt`.
- SEND:
  - `tx_start` is high only in the first SEND cycle.
  - On `tx_done`: if `last_r`, `grant` clears and next state is IDLE. Otherwise next state is LOAD with `gap_cnt` = 0.
- `req_ready` is 0 for non-granted requesters and for every requester outside LOAD.
- `tx_done` in IDLE or LOAD is ignored.
- `tx_start` never asserts unless `tx_ready` was high in the accepting cycle.
- `req_valid` on other requesters during a packet has no effect until the packet ends.
- A single-byte packet (`req_last` = 1 on the first byte) is legal.

## Timing
- From `req_valid` first seen in IDLE (cycle t):
  - `grant` is visible at t+1.
  - The earliest `req_ready` is at t+1.
  - `tx_start` and `tx_data` are at t+2.
- `tx_data` holds its value until the next accepted byte.
- `tx_done` at cycle d, packet ends: `grant` is 0 at d+1, and the next winner's grant is visible at d+2.
- `tx_done` at cycle d, packet continues: LOAD at d+1, so the next `tx_start` is at d+2 at the earliest.
- Watchdog: with `req_valid[g]` low from the first LOAD cycle L, `timeout` pulses at L+MAX_GAP-1 and `grant` is 0 at L+MAX_GAP.
- Config outputs change only on the cycle `grant` becomes non-zero.

## Test plan
- Reset mid-packet: assert `rst` while in SEND with `tx_start` high → all outputs are 0 that cycle. After release, a request from req2 alone is granted 1 cycle later (req0 is not favoured when it is not requesting).
- Round-robin: req0..req3 all valid, each sending single-byte packets 8'hA0..8'hA3 → `tx_data` sequence A0, A1, A2, A3, A0, with `grant` rotating 0001→0010→0100→1000→0001.
- Packet hold: req1 sends a 3-byte packet 8'h11, 8'h22, 8'h33 (`req_last` on 33) while req0 stays valid → req0 is not granted until after the `tx_done` for 33. `two_stop` and `odd_parity` equal req1's cfg throughout.
- Backpressure: `tx_ready` = 0 for 20 cycles with req3 valid → no `req_ready`, no `tx_start`, no timeout. `tx_ready` rises at cycle r → `tx_start` at r+1.
- Watchdog: MAX_GAP = 8, req2 drops `req_valid` after a non-last byte → `timeout` pulse with `timeout_id` = 2 exactly 7 cycles after LOAD entry, then `grant` = 0. A stray `tx_done` in IDLE causes no state change.
